seq_decoder: RTL



---
 rtl/seq_decoder_pkg.sv | 22 ++
 rtl/seq_decoder_onehot_core.sv | 24 ++
 rtl/seq_decoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seq_decoder_pkg.sv
// Shared types, sizing defaults and the one-hot helper for the seq_decoder family.
package seq_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      STROBE = 2'd2,
      SCAN   = 2'd3
   } state_t;

   localparam int N_MAX     = 8;
   localparam int N_DEF     = 4;
   localparam int DIV_W_DEF = 8;

   function automatic logic [(1<<N_MAX)-1:0] onehot(input logic [N_MAX-1:0] addr);
      logic [(1<<N_MAX)-1:0] r;
      r       = '0;
      r[addr] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/seq_decoder_onehot_core.sv
// Combinational N -> 2^N one-hot decoder shared by the accept and scan paths.
module onehot_core
   import seq_decoder_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N-1:0]        addr,
   output logic [(1<<N)-1:0]   onehot_out
);

   logic [(1<<N_MAX)-1:0] dec_full;

   assign dec_full   = onehot(N_MAX'(addr));
   assign onehot_out = dec_full[(1<<N)-1:0];

   // Lines above 2^N can never be selected for N < N_MAX.
   generate
      if (N < N_MAX) begin : g_hi
         logic [(1<<N_MAX)-(1<<N)-1:0] unused_hi;
         assign unused_hi = dec_full[(1<<N_MAX)-1:(1<<N)];
      end
   endgenerate

endmodule

// File: rtl/seq_decoder.sv
// Registered N-to-2^N one-hot decoder with valid/ready input, strobe/latch modes
// and an optional self-timed scan walk enabled by SEQ_DECODER_SCAN_EN.
module seq_decoder
   import seq_decoder_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0]        in_addr,
   input  logic                pulse_mode,
   input  logic                scan_start,
   input  logic [DIV_W-1:0]    scan_div,
   output logic [(1<<N)-1:0]   d,
   output logic                d_valid,
   output logic                busy
);

   state_t               state_q, state_d;
   logic [(1<<N)-1:0]    d_q, d_d;
   logic [N-1:0]         sel_addr;
   logic [(1<<N)-1:0]    sel_onehot;
   logic                 accept;

   onehot_core #(.N(N)) u_onehot (
      .addr       (sel_addr),
      .onehot_out (sel_onehot)
   );

`ifdef SEQ_DECODER_SCAN_EN
   logic [DIV_W-1:0]     div_q, div_d;
   logic [DIV_W-1:0]     cnt_q, cnt_d;
   logic [N-1:0]         idx_q, idx_d;

   assign in_ready = rst_n && en && (state_q != SCAN) && !scan_start;
   assign busy     = (state_q == SCAN);
`else
   logic unused_scan;

   assign unused_scan = ^{scan_start, scan_div};
   assign in_ready    = rst_n && en;
   assign busy        = 1'b0;
`endif

   assign accept  = in_valid && in_ready;
   assign d       = d_q;
   assign d_valid = |d_q;

   always_comb begin
      state_d  = state_q;
      d_d      = d_q;
      sel_addr = in_addr;
`ifdef SEQ_DECODER_SCAN_EN
      div_d    = div_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
`endif
      if (!en) begin
         state_d = IDLE;
         d_d     = '0;
      end
`ifdef SEQ_DECODER_SCAN_EN
      else if (state_q != SCAN && scan_start) begin
         // Scan wins over a simultaneous address; first line is driven at the start edge.
         state_d  = SCAN;
         div_d    = scan_div;
         cnt_d    = scan_div;
         idx_d    = '0;
         sel_addr = '0;
         d_d      = sel_onehot;
      end
      else if (state_q == SCAN) begin
         if (cnt_q == '0) begin
            if (&idx_q) begin
               state_d = IDLE;
               d_d     = '0;
            end else begin
               idx_d    = idx_q + 1'b1;
               cnt_d    = div_q;
               sel_addr = idx_q + 1'b1;
               d_d      = sel_onehot;
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
`endif
      else if (accept) begin
         state_d = pulse_mode ? STROBE : HOLD;
         d_d     = sel_onehot;
      end
      else if (state_q == STROBE) begin
         state_d = IDLE;
         d_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
      end
   end

`ifdef SEQ_DECODER_SCAN_EN
   // Dwell and line-index datapath; only read while in SCAN, so left unreset.
   always_ff @(posedge clk) begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
   end
`endif

endmodule
